// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types, constants and float32 helpers for the matrix multiplication engine
// Provides FLOAT_W, FLOAT_ZERO, the FSM state enum, elem_index(), idx_w(), fp_mul() and fp_add().
// fp_mul/fp_add: combinational float32, round-to-nearest-even, denormals flushed to signed zero,
// any NaN input yields the canonical quiet NaN 32'h7fc00000.
package matmul_pkg;
    localparam int FLOAT_W = 32;
    localparam logic [31:0] FLOAT_ZERO = 32'h00000000;
    localparam logic [31:0] FLOAT_NAN = 32'h7fc00000;

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;

    function automatic logic [31:0] elem_index(input logic [31:0] row, col, stride);
        return row * stride + col;
    endfunction

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Rounds a normalised mantissa and packs it; exponent carry from rounding falls out of the add.
    function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e, input logic [22:0] f, input logic g, st);
        logic [32:0] r;
        r = {e, f} + 33'(g & (st | f[0]));
        if (e <= 0) return {s, 31'd0};
        if ($signed(r[32:23]) >= 255) return {s, 8'hff, 23'd0};
        return {s, r[30:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, b);
        logic s;
        logic [47:0] p;
        logic signed [9:0] e;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0)) return FLOAT_NAN;
        if (a[30:23] == 8'hff || b[30:23] == 8'hff) return (a[30:23] == 0 || b[30:23] == 0) ? FLOAT_NAN : {s, 8'hff, 23'd0};
        if (a[30:23] == 0 || b[30:23] == 0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        return p[47] ? fp_pack(s, e + 10'sd1, p[46:24], p[23], |p[22:0]) : fp_pack(s, e, p[45:23], p[22], |p[21:0]);
    endfunction

    // Three extra low bits (guard/round/sticky) keep the aligned sum exact enough for correct rounding.
    function automatic logic [31:0] fp_add(input logic [31:0] a, b);
        logic [31:0] x, y, t;
        logic [26:0] mx, my;
        logic [27:0] sm;
        logic [7:0] d;
        logic signed [9:0] e;
        logic st;
        if ((a[30:23] == 8'hff && a[22:0] != 0) || (b[30:23] == 8'hff && b[22:0] != 0)) return FLOAT_NAN;
        if (a[30:23] == 8'hff && b[30:23] == 8'hff) return a[31] == b[31] ? a : FLOAT_NAN;
        if (a[30:23] == 8'hff) return a;
        if (b[30:23] == 8'hff) return b;
        x = a[30:23] == 0 ? {a[31], 31'd0} : a;
        y = b[30:23] == 0 ? {b[31], 31'd0} : b;
        if (x[30:0] < y[30:0]) begin
            t = x;
            x = y;
            y = t;
        end
        if (y[30:23] == 0) return x[30:0] == 0 ? {x[31] & y[31], 31'd0} : x;
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        d = x[30:23] - y[30:23];
        if (d > 26) my = 27'd1;
        else begin
            st = |(my & ~({27{1'b1}} << d));
            my = (my >> d) | {26'd0, st};
        end
        sm = x[31] == y[31] ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
        if (sm == 0) return FLOAT_ZERO;
        e = $signed({2'b0, x[30:23]});
        if (sm[27]) begin
            sm = {1'b0, sm[27:2], sm[1] | sm[0]};
            e = e + 10'sd1;
        end else
            for (int i = 0; i < 26; i++)
                if (!sm[26]) begin
                    sm = sm << 1;
                    e = e - 10'sd1;
                end
        return fp_pack(x[31], e, sm[25:3], sm[2], |sm[1:0]);
    endfunction
endpackage

// File: rtl/matmul_mac_lane.sv
// matmul_mac_lane: one float32 multiply-accumulate lane, acc <= acc + a*b
// Ports: clk, rst (sync, active-high), clear (zero acc), enable (accumulate), a/b operands, acc.
module matmul_mac_lane import matmul_pkg::*; (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [FLOAT_W-1:0] a,
    input  logic [FLOAT_W-1:0] b,
    output logic [FLOAT_W-1:0] acc
);
    always_ff @(posedge clk)
        if (rst || clear) acc <= FLOAT_ZERO;
        else if (enable) acc <= fp_add(acc, fp_mul(a, b));
endmodule

// File: rtl/matrix_multiplication_engine.sv
// matrix_multiplication_engine: sequential float32 result = A * B with B given transposed, MOD_COUNT MAC lanes
// Ports: clk, rst (sync, active-high); start/l/m/n/A/B_T request sampled while ready;
// ready (IDLE), busy (ACCUM/WRITE), done/err one-cycle pulses; result element (i,j) at word i*n+j.
// Build option: define MATMUL_RELU_EN to store 0 for any accumulator with the sign bit set.
module matrix_multiplication_engine import matmul_pkg::*; #(
    parameter int MAX_L = 4,
    parameter int MAX_M = 4,
    parameter int MAX_N = 4,
    parameter int MOD_COUNT = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [31:0]                        l,
    input  logic [31:0]                        m,
    input  logic [31:0]                        n,
    input  logic [FLOAT_W*MAX_L*MAX_M-1:0]     A,
    input  logic [FLOAT_W*MAX_N*MAX_M-1:0]     B_T,
    output logic                               ready,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [FLOAT_W*MAX_L*MAX_N-1:0]     result
);
    localparam int AW = idx_w(MAX_L * MAX_M);
    localparam int BW = idx_w(MAX_N * MAX_M);
    localparam int RW = idx_w(MAX_L * MAX_N);
    localparam int LW = idx_w(MOD_COUNT);

    state_t state;
    logic [31:0] lr, mr, nr, g, k;
    logic [FLOAT_W-1:0] a_in [MAX_L*MAX_M];
    logic [FLOAT_W-1:0] b_in [MAX_N*MAX_M];
    logic [FLOAT_W-1:0] a_buf [MAX_L*MAX_M];
    logic [FLOAT_W-1:0] b_buf [MAX_N*MAX_M];
    logic [FLOAT_W-1:0] res [MAX_L*MAX_N];
    logic [MOD_COUNT-1:0] act;
    logic [31:0] lane_e [MOD_COUNT];
    logic [FLOAT_W-1:0] lane_acc [MOD_COUNT];
    logic [FLOAT_W-1:0] lane_w [MOD_COUNT];
    logic bad, last;

    assign bad = l == 0 || m == 0 || n == 0 || l > MAX_L || m > MAX_M || n > MAX_N;
    assign last = (g + 1) * MOD_COUNT >= lr * nr;

    for (genvar i = 0; i < MAX_L * MAX_M; i++) begin : g_a
        assign a_in[i] = A[FLOAT_W*i +: FLOAT_W];
    end
    for (genvar i = 0; i < MAX_N * MAX_M; i++) begin : g_b
        assign b_in[i] = B_T[FLOAT_W*i +: FLOAT_W];
    end
    for (genvar i = 0; i < MAX_L * MAX_N; i++) begin : g_r
        assign result[FLOAT_W*i +: FLOAT_W] = res[i];
    end

    // Lane i of group g owns output element e = g*MOD_COUNT + i, i.e. row e/n, column e%n.
    for (genvar i = 0; i < MOD_COUNT; i++) begin : g_lane
        logic [31:0] row, col;
        assign lane_e[i] = g * MOD_COUNT + i;
        assign act[i] = lane_e[i] < lr * nr;
        assign row = lane_e[i] / nr;
        assign col = lane_e[i] % nr;
        matmul_mac_lane u_mac (
            .clk    (clk),
            .rst    (rst),
            .clear  (state == IDLE || state == WRITE),
            .enable (state == ACCUM && act[i]),
            .a      (a_buf[AW'(elem_index(row, k, mr))]),
            .b      (b_buf[BW'(elem_index(col, k, mr))]),
            .acc    (lane_acc[i])
        );
`ifdef MATMUL_RELU_EN
        assign lane_w[i] = lane_acc[i][FLOAT_W-1] ? FLOAT_ZERO : lane_acc[i];
`else
        assign lane_w[i] = lane_acc[i];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ready <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            lr <= 32'd1;
            mr <= 32'd1;
            nr <= 32'd1;
            g <= '0;
            k <= '0;
            res <= '{default: FLOAT_ZERO};
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE:
                    if (start && bad) err <= 1'b1;
                    else if (start) begin
                        a_buf <= a_in;
                        b_buf <= b_in;
                        lr <= l;
                        mr <= m;
                        nr <= n;
                        res <= '{default: FLOAT_ZERO};
                        g <= '0;
                        k <= '0;
                        state <= ACCUM;
                        ready <= 1'b0;
                        busy <= 1'b1;
                    end
                ACCUM: begin
                    k <= k + 1;
                    state <= k == mr - 1 ? WRITE : ACCUM;
                end
                WRITE: begin
                    for (int x = 0; x < MOD_COUNT; x++)
                        if (act[LW'(x)]) res[RW'(lane_e[LW'(x)])] <= lane_w[LW'(x)];
                    k <= '0;
                    g <= last ? g : g + 1;
                    state <= last ? DONE : ACCUM;
                    busy <= !last;
                    done <= last;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
